// File: rtl/ule_pkg.sv
// Shared constants for the ULE arbiter: state encoding, default sizes, width helper.
package ule_pkg;

   localparam int unsigned N_DEF     = 4;
   localparam int unsigned WIDTH_DEF = 8;

   // FSM encoding; 2'b11 is illegal and recovers to IDLE
   localparam logic [1:0] IDLE = 2'b00;
   localparam logic [1:0] EXEC = 2'b01;
   localparam logic [1:0] DONE = 2'b10;

   // Ceiling log2, used to size the requester ID
   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      for (int unsigned i = 0; i < 32; i++) begin
         if ((64'(1) << i) < 64'(v)) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/ule_core.sv
// Unsigned A <= B compare: carry-out of B + ~A + 1, sum bits never formed.
module ule_core
   import ule_pkg::*;
#(
   parameter int unsigned WIDTH = WIDTH_DEF
) (
   input  logic [WIDTH-1:0] ra,
   input  logic [WIDTH-1:0] rb,
   output logic             le_c
);

   logic c;

   // Ripple carry through the inverted-A adder; only the final carry is kept
   always_comb begin
      c = 1'b1;
      for (int unsigned i = 0; i < WIDTH; i++) begin
         c = (rb[i] & ~ra[i]) | (c & (rb[i] ^ ~ra[i]));
      end
      le_c = c;
   end

endmodule

// File: rtl/ule_arbiter.sv
// Round-robin scheduler sharing one ule_core comparator between N requesters.
module ule_arbiter
   import ule_pkg::*;
#(
   parameter  int unsigned N     = N_DEF,
   parameter  int unsigned WIDTH = WIDTH_DEF,
   localparam int unsigned IDW   = clog2(N)
) (
   input  logic               clk,
   input  logic               resetn,
   input  logic [N-1:0]       req,
   input  logic [N*WIDTH-1:0] a,
   input  logic [N*WIDTH-1:0] b,
   output logic [N-1:0]       gnt,
   output logic               valid,
   input  logic               rdy,
   output logic [IDW-1:0]     id,
   output logic               le,
   output logic               busy
);

   logic [1:0]       state_q, state_d;
   logic [IDW-1:0]   ptr_q;
   logic [IDW-1:0]   sel;
   logic [IDW-1:0]   cand;
   logic             any_req;
   logic             grant;
   logic [WIDTH-1:0] ra_q, rb_q;
   logic [IDW-1:0]   rid_q;
   logic [IDW-1:0]   id_q;
   logic             le_q;
   logic             le_c;

   // Rotating priority: first set request at or above ptr_q, wrapping
   always_comb begin
      sel     = '0;
      cand    = '0;
      any_req = 1'b0;
      for (int unsigned k = 0; k < N; k++) begin
         cand = ptr_q + IDW'(k);
         if (!any_req && req[cand]) begin
            any_req = 1'b1;
            sel     = cand;
         end
      end
   end

   // Next state and grant pulse; grant only out of reset and in IDLE
   always_comb begin
      state_d = state_q;
      gnt     = '0;
      grant   = 1'b0;
      case (state_q)
         IDLE: begin
            if (any_req && resetn) begin
               gnt[sel] = 1'b1;
               grant    = 1'b1;
               state_d  = EXEC;
            end
         end
         EXEC:    state_d = DONE;
         DONE:    if (rdy) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state_q <= IDLE;
      else         state_q <= state_d;
   end

   // Capture granted operands, tag and advance the round-robin pointer
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         ptr_q <= '0;
         ra_q  <= '0;
         rb_q  <= '0;
         rid_q <= '0;
      end else if (grant) begin
         ptr_q <= sel + IDW'(1);
         ra_q  <= a[32'(sel)*WIDTH +: WIDTH];
         rb_q  <= b[32'(sel)*WIDTH +: WIDTH];
         rid_q <= sel;
      end
   end

   ule_core #(.WIDTH(WIDTH)) u_core (
      .ra   (ra_q),
      .rb   (rb_q),
      .le_c (le_c)
   );

   // Result registers update only when leaving EXEC, then hold
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         id_q <= '0;
         le_q <= 1'b0;
      end else if (state_q == EXEC) begin
         id_q <= rid_q;
         le_q <= le_c;
      end
   end

   assign id    = id_q;
   assign le    = le_q;
   assign valid = (state_q == DONE);
   assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_ule_arbiter.sv
// Randomized scoreboard bench for ule_arbiter (N=4, WIDTH=8).
module tb_ule_arbiter;

   localparam int unsigned N   = 4;
   localparam int unsigned W   = 8;
   localparam int unsigned IDW = 2;

   logic           clk = 1'b0;
   logic           resetn;
   logic           rdy;
   logic [N-1:0]   req;
   logic [N-1:0]   gnt;
   logic [N*W-1:0] a, b;
   logic           valid, le, busy;
   logic [IDW-1:0] id;

   ule_arbiter #(.N(N), .WIDTH(W)) dut (
      .clk    (clk),
      .resetn (resetn),
      .req    (req),
      .a      (a),
      .b      (b),
      .gnt    (gnt),
      .valid  (valid),
      .rdy    (rdy),
      .id     (id),
      .le     (le),
      .busy   (busy)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- reference model + scoreboard monitor ----------------
   typedef struct packed {
      logic [IDW-1:0] id;
      logic           le;
   } exp_t;

   exp_t           sbq[$];
   exp_t           e;
   int unsigned    mptr    = 0;
   bit             infl    = 1'b0;
   int             cyc     = 0;
   int             gcyc    = 0;
   int             msel;
   int             idx;
   logic [N-1:0]   eg;
   logic           exp_valid, exp_busy;
   logic [IDW-1:0] last_id = '0;
   logic           last_le = 1'b0;

   always begin
      @(negedge clk);
      #3;
      cyc++;
      if (resetn !== 1'b1) begin
         chk("rst_gnt",   32'(gnt),   0);
         chk("rst_valid", 32'(valid), 0);
         chk("rst_busy",  32'(busy),  0);
         chk("rst_id",    32'(id),    0);
         chk("rst_le",    32'(le),    0);
         sbq.delete();
         infl    = 1'b0;
         mptr    = 0;
         last_id = '0;
         last_le = 1'b0;
      end else begin
         // who should be granted this cycle
         eg   = '0;
         msel = -1;
         if (!infl && req != '0) begin
            for (int k = 0; k < N; k++) begin
               idx = (int'(mptr) + k) % N;
               if (msel < 0 && req[idx]) msel = idx;
            end
            eg[msel] = 1'b1;
         end
         exp_valid = infl && (cyc >= gcyc + 2);
         exp_busy  = infl && (cyc > gcyc);
         chk("gnt",   32'(gnt),   32'(eg));
         chk("valid", 32'(valid), 32'(exp_valid));
         chk("busy",  32'(busy),  32'(exp_busy));
         if (exp_valid && sbq.size() > 0) begin
            chk("id", 32'(id), 32'(sbq[0].id));
            chk("le", 32'(le), 32'(sbq[0].le));
         end else if (!exp_valid) begin
            chk("id_hold", 32'(id), 32'(last_id));
            chk("le_hold", 32'(le), 32'(last_le));
         end
         if (exp_valid && rdy === 1'b1) begin
            if (sbq.size() > 0) begin
               last_id = sbq[0].id;
               last_le = sbq[0].le;
               void'(sbq.pop_front());
            end
            infl = 1'b0;
         end
         if (msel >= 0) begin
            e.id = IDW'(msel);
            e.le = (a[msel*W +: W] <= b[msel*W +: W]);
            sbq.push_back(e);
            infl = 1'b1;
            gcyc = cyc;
            mptr = (msel + 1) % N;
         end
      end
   end

   // ---------------- stimulus ----------------
   bit           pend [N];
   logic [W-1:0] oa   [N];
   logic [W-1:0] ob   [N];
   logic         rst_v, rdy_v;
   logic [N-1:0] last_gnt;
   int           outstanding = 0;
   logic [W-1:0] vals [16];

   function automatic int pend_cnt();
      int c = 0;
      for (int i = 0; i < N; i++) c += int'(pend[i]);
      return c;
   endfunction

   // one clock: drive at falling edge, observe grants/handshakes before rising edge
   task automatic step();
      @(negedge clk);
      resetn = rst_v;
      rdy    = rdy_v;
      for (int i = 0; i < N; i++) begin
         req[i]       = pend[i];
         a[i*W +: W]  = oa[i];
         b[i*W +: W]  = ob[i];
      end
      #3;
      last_gnt = gnt;
      if (!resetn) outstanding = 0;
      else begin
         if (valid && rdy) outstanding--;
         if (gnt != '0) outstanding++;
      end
      for (int i = 0; i < N; i++) if (gnt[i]) pend[i] = 1'b0;
   endtask

   task automatic drain(input int budget);
      int n = 0;
      while ((pend_cnt() > 0 || outstanding > 0) && n < budget) begin
         step();
         n++;
      end
      chk("drain", 32'(pend_cnt() + outstanding), 0);
   endtask

   task automatic single(input int i, input logic [W-1:0] va, input logic [W-1:0] vb);
      pend[i] = 1'b1;
      oa[i]   = va;
      ob[i]   = vb;
      drain(40);
   endtask

   initial begin
      resetn = 1'b0;
      rdy    = 1'b1;
      req    = '0;
      a      = '0;
      b      = '0;
      rst_v  = 1'b0;
      rdy_v  = 1'b1;
      for (int i = 0; i < N; i++) begin
         pend[i] = 1'b0;
         oa[i]   = '0;
         ob[i]   = '0;
      end

      // reset, then idle with no requests
      repeat (3) step();
      rst_v = 1'b1;
      repeat (10) step();

      // directed single transactions on requester 0
      single(0, 8'd3,  8'd3);
      single(0, 8'hFF, 8'h00);
      single(0, 8'h00, 8'hFF);

      // backpressure: requester 2 holds the result while requester 0 waits
      rdy_v   = 1'b0;
      pend[2] = 1'b1;
      oa[2]   = 8'd10;
      ob[2]   = 8'd9;
      for (int n = 0; n < 20 && pend[2]; n++) step();
      chk("bp_grant2", 32'(pend[2]), 0);
      pend[0] = 1'b1;
      oa[0]   = 8'd1;
      ob[0]   = 8'd2;
      for (int n = 0; n < 20 && !valid; n++) step();
      chk("bp_valid", 32'(valid), 1);
      repeat (5) step();
      rdy_v = 1'b1;
      drain(40);

      // reset while requester 0 is in EXEC, requests 1 and 3 pending across it
      pend[0] = 1'b1;
      oa[0]   = 8'd5;
      ob[0]   = 8'd4;
      for (int n = 0; n < 20 && last_gnt == '0; n++) step();
      chk("mr_grant", 32'(last_gnt), 32'h1);
      rst_v   = 1'b0;
      pend[1] = 1'b1; oa[1] = 8'd7; ob[1] = 8'd200;
      pend[3] = 1'b1; oa[3] = 8'd9; ob[3] = 8'd8;
      step();
      step();
      rst_v = 1'b1;
      step();
      chk("mr_first", 32'(last_gnt), 32'h2);
      drain(60);

      // round-robin under continuous requests, each refilled after its grant
      for (int n = 0; n < 150; n++) begin
         for (int i = 0; i < N; i++) begin
            if (!pend[i]) begin
               pend[i] = 1'b1;
               oa[i]   = W'($urandom);
               ob[i]   = W'($urandom);
            end
         end
         step();
      end
      drain(60);

      // random requests, withdrawals and backpressure
      for (int n = 0; n < 500; n++) begin
         rdy_v = ($urandom_range(0, 3) != 0);
         for (int i = 0; i < N; i++) begin
            if (!pend[i] && $urandom_range(0, 2) == 0) begin
               pend[i] = 1'b1;
               oa[i]   = ($urandom_range(0, 3) == 0) ? ob[i] : W'($urandom);
               ob[i]   = W'($urandom);
            end else if (pend[i] && $urandom_range(0, 19) == 0) begin
               pend[i] = 1'b0;
            end
         end
         step();
      end
      rdy_v = 1'b1;
      drain(100);

      // compare sweep on requester 3: corner grid plus random pairs
      vals = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h40, 8'h7E, 8'h7F, 8'h80,
               8'h81, 8'hC0, 8'hFD, 8'hFE, 8'hFF, 8'h55, 8'hAA, 8'h10};
      for (int i = 0; i < 16; i++)
         for (int j = 0; j < 16; j++)
            single(3, vals[i], vals[j]);
      for (int n = 0; n < 1200; n++) single(3, W'($urandom), W'($urandom));

      repeat (5) step();
      chk("sb_empty", 32'(sbq.size()), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
